// File: rtl/cursor_pkg.sv
// Shared types for the board-game cursor controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cursor_pkg;

   typedef enum logic [1:0] {IDLE, STEP, HOLD} cursor_state_t;
   typedef enum logic {AXIS_H, AXIS_V} axis_t;

   localparam int POS_W = 5;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: SYNC_STAGES-deep synchronizer plus falling-edge (press) detect.
// Latency: press pulses in the cycle after the SYNC_STAGES-th edge that sampled btn_n low.
// Backpressure: none; press is a single-cycle pulse that is lost if the consumer ignores it.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n      : raw active-low button (asynchronous)
//   level_n    : synchronized button level (0 = held)
//   press      : one-cycle pulse on a synchronized 1->0 transition
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level_n,
   output logic press
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   seen_q;
   logic                   armed_q;

   // The chain resets to "released", so a button held through reset would
   // look like a fresh fall once the chain refills. armed_q blocks press
   // until the chain has shown a genuine released level sampled after reset
   // (seen_q guarantees sync_q[0] holds a real sample, not the reset value).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         seen_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
         prev_q <= sync_q[SYNC_STAGES-1];
         seen_q <= 1'b1;
         if (seen_q && (&sync_q)) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign level_n = sync_q[SYNC_STAGES-1];
   assign press   = armed_q & prev_q & ~level_n;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor controller: conditions H/V buttons, arbitrates, applies bounded steps with hold-to-repeat.
// Latency: row/col/moved update SYNC_STAGES+1 edges after the first edge sampling a button low.
// Backpressure: none; steps are applied unconditionally, refused edge steps pulse blocked instead.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   move_h_n, move_v_n : raw active-low buttons
//   direction          : 1 = right/up, 0 = left/down, sampled on the step edge
//   enable             : 0 freezes the cursor and drops the FSM to IDLE
//   home               : synchronous return to HOME_ROW/HOME_COL (wins over everything but reset)
//   row, col           : registered cursor position
//   moved, blocked     : one-cycle pulses for an applied / refused step
module cursor_ctrl
   import cursor_pkg::*;
#(
   parameter int ROWS         = 6,
   parameter int COLS         = 6,
   parameter int HOME_ROW     = 0,
   parameter int HOME_COL     = 0,
   parameter int SYNC_STAGES  = 2,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             move_h_n,
   input  logic             move_v_n,
   input  logic             direction,
   input  logic             enable,
   input  logic             home,
   output logic [POS_W-1:0] row,
   output logic [POS_W-1:0] col,
   output logic             moved,
   output logic             blocked
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [POS_W-1:0] ROW_MAX    = POS_W'(ROWS - 1);
   localparam logic [POS_W-1:0] COL_MAX    = POS_W'(COLS - 1);
   localparam logic [POS_W-1:0] ROW_HOME   = POS_W'(HOME_ROW);
   localparam logic [POS_W-1:0] COL_HOME   = POS_W'(HOME_COL);

   logic h_level_n, h_press;
   logic v_level_n, v_press;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (move_h_n),
      .level_n (h_level_n),
      .press   (h_press)
   );

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_v (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (move_v_n),
      .level_n (v_level_n),
      .press   (v_press)
   );

   cursor_state_t    state_q;
   axis_t            axis_q;
   logic [CNT_W-1:0] cnt_q;
   logic [POS_W-1:0] row_q, col_q;
   logic             moved_q, blocked_q;

   axis_t            step_axis;
   logic             step_ok;
   logic [POS_W-1:0] row_nxt, col_nxt;
   logic             active_level_n;

   // Axis for a step taken this edge: a fresh press in IDLE (H beats V),
   // otherwise the axis latched on the original press during auto-repeat.
   always_comb begin
      step_axis = axis_q;
      if (state_q == IDLE) begin
         step_axis = h_press ? AXIS_H : AXIS_V;
      end
   end

   assign active_level_n = (axis_q == AXIS_H) ? h_level_n : v_level_n;

   // Bounds are checked before the increment/decrement so the 5-bit position
   // never wraps. Row 0 is the top of the grid, so "up" decrements.
   always_comb begin
      step_ok = 1'b0;
      row_nxt = row_q;
      col_nxt = col_q;
      if (step_axis == AXIS_H) begin
         if (direction) begin
            if (col_q < COL_MAX) begin
               step_ok = 1'b1;
               col_nxt = col_q + POS_W'(1);
            end
         end else if (col_q != '0) begin
            step_ok = 1'b1;
            col_nxt = col_q - POS_W'(1);
         end
      end else begin
         if (direction) begin
            if (row_q != '0) begin
               step_ok = 1'b1;
               row_nxt = row_q - POS_W'(1);
            end
         end else if (row_q < ROW_MAX) begin
            step_ok = 1'b1;
            row_nxt = row_q + POS_W'(1);
         end
      end
   end

   // The step is applied on the edge that enters STEP, so moved/blocked are
   // visible while the FSM sits in STEP. The repeat counter is loaded on that
   // same edge and only counts down in HOLD; a step fires when it would reach
   // zero, giving exactly REPEAT_DELAY / REPEAT_RATE cycles between steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         axis_q    <= AXIS_H;
         cnt_q     <= '0;
         row_q     <= ROW_HOME;
         col_q     <= COL_HOME;
         moved_q   <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         moved_q   <= 1'b0;
         blocked_q <= 1'b0;
         if (home) begin
            row_q   <= ROW_HOME;
            col_q   <= COL_HOME;
            state_q <= IDLE;
            cnt_q   <= '0;
         end else if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (h_press || v_press) begin
                     axis_q    <= step_axis;
                     row_q     <= row_nxt;
                     col_q     <= col_nxt;
                     moved_q   <= step_ok;
                     blocked_q <= ~step_ok;
                     cnt_q     <= DELAY_LOAD;
                     state_q   <= STEP;
                  end
               end
               STEP: begin
                  state_q <= HOLD;
               end
               HOLD: begin
                  if (active_level_n) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q <= CNT_W'(1)) begin
                     row_q     <= row_nxt;
                     col_q     <= col_nxt;
                     moved_q   <= step_ok;
                     blocked_q <= ~step_ok;
                     cnt_q     <= RATE_LOAD;
                     state_q   <= STEP;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign row     = row_q;
   assign col     = col_q;
   assign moved   = moved_q;
   assign blocked = blocked_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with short repeat timing (delay 4, rate 2).
// Latency: n/a.
// Backpressure: n/a.
module tb_cursor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       move_h_n;
   logic       move_v_n;
   logic       direction;
   logic       enable;
   logic       home;
   logic [4:0] row;
   logic [4:0] col;
   logic       moved;
   logic       blocked;

   int n_checks = 0;
   int n_fail   = 0;
   int tap_moved;
   int tap_blocked;
   int win_moved;
   int win_blocked;
   int max_col;
   int b7;
   int b8;
   int m3;

   always #5 clk = ~clk;

   cursor_ctrl #(
      .ROWS         (6),
      .COLS         (6),
      .HOME_ROW     (0),
      .HOME_COL     (0),
      .SYNC_STAGES  (2),
      .REPEAT_DELAY (4),
      .REPEAT_RATE  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .move_h_n  (move_h_n),
      .move_v_n  (move_v_n),
      .direction (direction),
      .enable    (enable),
      .home      (home),
      .row       (row),
      .col       (col),
      .moved     (moved),
      .blocked   (blocked)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Run n cycles (sampling at each falling edge) and count output pulses.
   task automatic run(input int n);
      win_moved   = 0;
      win_blocked = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         win_moved   += int'(moved);
         win_blocked += int'(blocked);
      end
   endtask

   // Short press: low for three sampling edges, then release and settle.
   task automatic tap(input logic is_h, input logic dir);
      direction   = dir;
      tap_moved   = 0;
      tap_blocked = 0;
      if (is_h) move_h_n = 1'b0;
      else      move_v_n = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         tap_moved   += int'(moved);
         tap_blocked += int'(blocked);
         if (i == 2) begin
            move_h_n = 1'b1;
            move_v_n = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      move_h_n  = 1'b1;
      move_v_n  = 1'b1;
      direction = 1'b0;
      enable    = 1'b1;
      home      = 1'b0;
      #1;
      check("rst_row", int'(row), 0);
      check("rst_col", int'(col), 0);
      check("rst_moved", int'(moved), 0);
      check("rst_blocked", int'(blocked), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(4);

      // Single press: step appears after exactly three edges.
      direction = 1'b1;
      move_h_n  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("lat_col_e2", int'(col), 0);
      check("lat_moved_e2", int'(moved), 0);
      @(negedge clk);
      check("lat_col_e3", int'(col), 1);
      check("lat_moved_e3", int'(moved), 1);
      move_h_n = 1'b1;
      @(negedge clk);
      check("lat_moved_e4", int'(moved), 0);
      run(6);
      check("lat_extra_moves", win_moved, 0);
      check("lat_row", int'(row), 0);

      for (int i = 0; i < 3; i++) tap(1'b1, 1'b1);
      check("walk_col4", int'(col), 4);

      // Hold right from col 4: one move, then blocked every 2 cycles after a 4-cycle delay.
      direction = 1'b1;
      move_h_n  = 1'b0;
      win_moved = 0; win_blocked = 0; max_col = 0; b7 = 0; b8 = 0; m3 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         win_moved   += int'(moved);
         win_blocked += int'(blocked);
         if (int'(col) > max_col) max_col = int'(col);
         if (k == 3) m3 = int'(moved);
         if (k == 7) b7 = int'(blocked);
         if (k == 8) b8 = int'(blocked);
      end
      check("hold_first_move", m3, 1);
      check("hold_moves", win_moved, 1);
      check("hold_blocked", win_blocked, 7);
      check("hold_blk_k7", b7, 1);
      check("hold_blk_k8", b8, 0);
      check("hold_max_col", max_col, 5);
      move_h_n = 1'b1;
      run(8);
      check("hold_col_end", int'(col), 5);

      // Upward step at row 0 is refused.
      tap(1'b0, 1'b1);
      check("top_edge_moved", tap_moved, 0);
      check("top_edge_blocked", tap_blocked, 1);
      check("top_edge_row", int'(row), 0);

      home = 1'b1;
      @(negedge clk);
      home = 1'b0;
      check("home_row", int'(row), 0);
      check("home_col", int'(col), 0);

      tap(1'b1, 1'b1); tap(1'b1, 1'b1);
      tap(1'b0, 1'b0); tap(1'b0, 1'b0);
      check("at22_row", int'(row), 2);
      check("at22_col", int'(col), 2);

      // Simultaneous press, direction 0: horizontal wins, vertical is swallowed.
      direction = 1'b0;
      move_h_n  = 1'b0;
      move_v_n  = 1'b0;
      run(3);
      check("both_moves", win_moved, 1);
      check("both_col", int'(col), 1);
      check("both_row", int'(row), 2);
      move_h_n = 1'b1;
      run(12);
      check("both_vheld_moves", win_moved, 0);
      check("both_vheld_row", int'(row), 2);
      move_v_n = 1'b1;
      run(6);
      tap(1'b0, 1'b0);
      check("repress_moved", tap_moved, 1);
      check("repress_row", int'(row), 3);

      // Disabled: no movement; enabling with the button held does not step.
      enable    = 1'b0;
      direction = 1'b0;
      move_v_n  = 1'b0;
      run(8);
      check("dis_moved", win_moved, 0);
      check("dis_blocked", win_blocked, 0);
      check("dis_row", int'(row), 3);
      enable = 1'b1;
      run(10);
      check("en_held_moved", win_moved, 0);
      check("en_held_row", int'(row), 3);
      move_v_n = 1'b1;
      run(6);
      tap(1'b0, 1'b0);
      check("en_repress_moved", tap_moved, 1);
      check("en_repress_row", int'(row), 4);

      tap(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tap(1'b1, 1'b1);
      check("at34_row", int'(row), 3);
      check("at34_col", int'(col), 4);

      // home in the cycle a step would be applied.
      direction = 1'b1;
      move_h_n  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      home = 1'b1;
      @(negedge clk);
      home = 1'b0;
      check("homestep_row", int'(row), 0);
      check("homestep_col", int'(col), 0);
      check("homestep_moved", int'(moved), 0);
      move_h_n = 1'b1;
      run(8);
      check("homestep_late_moves", win_moved, 0);
      check("homestep_col_end", int'(col), 0);

      tap(1'b1, 1'b1);
      tap(1'b0, 1'b0);
      check("at11_row", int'(row), 1);
      check("at11_col", int'(col), 1);

      // Reset while holding: immediate home, held button does not step afterwards.
      direction = 1'b1;
      move_h_n  = 1'b0;
      run(5);
      check("pre_rst_col", int'(col), 2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_row", int'(row), 0);
      check("mid_rst_col", int'(col), 0);
      check("mid_rst_moved", int'(moved), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(12);
      check("post_rst_held_moves", win_moved + win_blocked, 0);
      check("post_rst_col", int'(col), 0);
      move_h_n = 1'b1;
      run(6);
      tap(1'b1, 1'b1);
      check("post_rst_tap_moved", tap_moved, 1);
      check("post_rst_tap_col", int'(col), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
